// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a fetch port and a load/store port onto one memory port.
// Data wins by default; a pending fetch wins after STARVE_MAX consecutive data grants.
// Define MEM_ARB_TIMEOUT_EN to abort a BUSY transaction after 255 cycles with err and 32'hDEADBEEF.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          err
);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d;
  logic [SW-1:0] starve_q, starve_d;
  logic mem_req_q, mem_req_d;
  logic mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic if_ack_q, if_ack_d;
  logic d_ack_q, d_ack_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic [DW-1:0] rdata_in;
  logic d_win;
  logic timeout;
`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;
  logic err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
  assign mem_req = mem_req_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack = if_ack_q;
  assign d_ack = d_ack_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata = d_rdata_q;
  // next-state: arbitrate in IDLE, hold the bus in BUSY, single-cycle ack in DONE
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    starve_d = starve_q;
    mem_req_d = mem_req_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d = d_rdata_q;
    if_ack_d = 1'b0;
    d_ack_d = 1'b0;
    d_win = d_req && !(if_req && starve_q == SMAX);
`ifdef MEM_ARB_TIMEOUT_EN
    wait_d = (state_q == BUSY) ? wait_q + 8'd1 : 8'd0;
    timeout = state_q == BUSY && !mem_ack && wait_q == 8'hFF;
    err_d = timeout;
    rdata_in = timeout ? DW'(32'hDEADBEEF) : mem_rdata;
`else
    timeout = 1'b0;
    rdata_in = mem_rdata;
`endif
    case (state_q)
      IDLE: if (d_req || if_req) begin
        state_d = BUSY;
        owner_d = d_win;
        mem_req_d = 1'b1;
        mem_we_d = d_win && d_we;
        mem_addr_d = d_win ? d_addr : if_addr;
        mem_wdata_d = d_win ? d_wdata : '0;
        starve_d = !d_win ? '0 : (if_req && starve_q != SMAX) ? starve_q + 1'b1 : starve_q;
      end
      BUSY: if (mem_ack || timeout) begin
        state_d = DONE;
        mem_req_d = 1'b0;
        if_ack_d = !owner_q;
        d_ack_d = owner_q;
        if_rdata_d = owner_q ? if_rdata_q : rdata_in;
        d_rdata_d = owner_q ? rdata_in : d_rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers, cleared asynchronously so a reset abandons any transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      starve_q <= '0;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      if_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      starve_q <= starve_d;
      mem_req_q <= mem_req_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q <= if_ack_d;
      d_ack_q <= d_ack_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_q <= wait_d;
      err_q <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a latency-programmable memory model
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic if_req, d_req, d_we, mem_ack, if_ack, d_ack, mem_req, mem_we, err;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata, if_rdata, d_rdata, mem_addr, mem_wdata;
  int lat = 0;
  bit hang = 0;
  int n_chk = 0, n_fail = 0;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} grant_t;
  typedef struct {logic we; logic [31:0] rdata;} dexp_t;
  grant_t gq[$];
  logic [31:0] iq[$];
  dexp_t dq[$];

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h12345778;
  endfunction

  task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic raise(input bit d, input bit we, input logic [31:0] a, input logic [31:0] wd);
    if (d) begin
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
      dq.push_back('{we, mdata(a)});
    end else begin
      if_req = 1'b1; if_addr = a;
      iq.push_back(mdata(a));
    end
  endtask

  task automatic expect_grant(input bit d, input bit we, input logic [31:0] a, input logic [31:0] wd);
    gq.push_back('{d && we, a, wd});
  endtask

  task automatic wait_ack(input bit d, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(d ? d_ack : if_ack) && n < 2000);
    if (n >= 2000) check(d ? "d_ack_timeout" : "if_ack_timeout", 0, 1);
  endtask

  task automatic do_op(input bit d, input bit we, input logic [31:0] a, input logic [31:0] wd, input bit chk);
    int n;
    @(negedge clk);
    raise(d, we, a, wd);
    expect_grant(d, we, a, wd);
    wait_ack(d, n);
    if (d) d_req = 1'b0; else if_req = 1'b0;
    if (chk) check("turnaround", 96'(n), 96'(2 + lat));
  endtask

  // memory model: ack after lat extra cycles of mem_req, data derived from address
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ack || rst) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (mem_req && !hang) begin
        if (cnt >= lat) begin
          mem_ack = 1'b1;
          mem_rdata = mdata(mem_addr);
        end else cnt++;
      end
    end
  end

  // monitor: grant contents, bus stability, ack timing/exclusivity and returned data
  initial begin
    logic prev_req;
    logic [64:0] prev_bus;
    grant_t g;
    dexp_t e;
    prev_req = 1'b0;
    prev_bus = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req === 1'b1 && !prev_req) begin
        if (gq.size() == 0) check("grant_unexp", 0, 1);
        else begin
          g = gq.pop_front();
          check("grant_addr", mem_addr, g.addr);
          check("grant_we", mem_we, g.we);
          if (g.we) check("grant_wdata", mem_wdata, g.wdata);
        end
      end else if (mem_req === 1'b1) check("busy_stable", {mem_we, mem_addr, mem_wdata}, prev_bus);
      if (if_ack === 1'b1) begin
        if (iq.size() == 0) check("if_ack_unexp", 0, 1);
        else check("if_rdata", if_rdata, iq.pop_front());
      end
      if (d_ack === 1'b1) begin
        if (dq.size() == 0) check("d_ack_unexp", 0, 1);
        else begin
          e = dq.pop_front();
          if (!e.we) check("d_rdata", d_rdata, e.rdata);
        end
      end
      if ((if_ack === 1'b1 || d_ack === 1'b1) && err !== 1'b1) check("ack_after_mem_ack", mem_ack, 1);
      if (if_ack === 1'b1 || d_ack === 1'b1) check("ack_excl", if_ack & d_ack, 0);
      prev_req = (mem_req === 1'b1);
      prev_bus = {mem_we, mem_addr, mem_wdata};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    if_req = 0; d_req = 0; d_we = 0; if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, '0);
    check("rst_acks", {if_ack, d_ack, err}, '0);
    check("rst_rdata", {if_rdata, d_rdata}, '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_req", mem_req, 0);
    // fetch only, minimum turnaround
    do_op(0, 0, 32'h100, 0, 1);
    check("if_rdata_const", if_rdata, 32'h12345678);
    check("d_ack_quiet", d_ack, 0);
    // data write then read alone
    do_op(1, 1, 32'h240, 32'h0BADF00D, 1);
    do_op(1, 0, 32'h244, 0, 1);
    // simultaneous: data write first, fetch after
    @(negedge clk);
    raise(1, 1, 32'h200, 32'hA5A5A5A5);
    raise(0, 0, 32'h180, 0);
    expect_grant(1, 1, 32'h200, 32'hA5A5A5A5);
    expect_grant(0, 0, 32'h180, 0);
    fork
      begin wait_ack(1, n); d_req = 1'b0; end
      begin wait_ack(0, n); if_req = 1'b0; end
    join
    // starvation: d_req held with fetch pending -> 3 data grants then fetch
    @(negedge clk);
    raise(0, 0, 32'h300, 0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      dq.push_back('{1'b0, mdata(32'h400)});
      expect_grant(1, 0, 32'h400, 0);
    end
    expect_grant(0, 0, 32'h300, 0);
    wait_ack(0, n);
    if_req = 1'b0;
    d_req = 1'b0;
    // starve count cleared: a simultaneous pair now goes to data first
    @(negedge clk);
    raise(1, 0, 32'h410, 0);
    raise(0, 0, 32'h310, 0);
    expect_grant(1, 0, 32'h410, 0);
    expect_grant(0, 0, 32'h310, 0);
    fork
      begin wait_ack(1, n); d_req = 1'b0; end
      begin wait_ack(0, n); if_req = 1'b0; end
    join
    // fetch rising while data owns a slow bus waits its turn
    lat = 4;
    fork
      do_op(1, 0, 32'h420, 0, 1);
      begin repeat (2) @(negedge clk); do_op(0, 0, 32'h320, 0, 0); end
    join
    // slow memory
    lat = 10;
    do_op(0, 0, 32'h140, 0, 1);
    do_op(1, 1, 32'h440, 32'h5555AAAA, 1);
    lat = 0;
    // reset during BUSY abandons the transfer
    @(negedge clk);
    hang = 1'b1;
    if_req = 1'b1; if_addr = 32'h500;
    expect_grant(0, 0, 32'h500, 0);
    n = 0;
    while (mem_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("rst_busy_reached", mem_req, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, '0);
    check("arst_acks", {if_ack, d_ack, err}, '0);
    check("arst_rdata", {if_rdata, d_rdata}, '0);
    @(negedge clk);
    if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    hang = 1'b0;
    do_op(0, 0, 32'h600, 0, 1);
`ifdef MEM_ARB_TIMEOUT_EN
    @(negedge clk);
    hang = 1'b1;
    if_req = 1'b1; if_addr = 32'h700;
    iq.push_back(32'hDEADBEEF);
    expect_grant(0, 0, 32'h700, 0);
    wait_ack(0, n);
    check("tmo_err", err, 1);
    if_req = 1'b0;
    @(negedge clk);
    check("tmo_err_pulse", err, 0);
    hang = 1'b0;
`endif
    repeat (5) @(negedge clk);
    check("gq_drained", 96'(gq.size()), 0);
    check("iq_drained", 96'(iq.size()), 0);
    check("dq_drained", 96'(dq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
